// File: rtl/seq_detect_param_pkg.sv
// Shared helpers for the slow-sampled serial pattern detector and its tick generator.
package seq_detect_param_pkg;

  localparam int unsigned MinDiv    = 2;
  localparam int unsigned MaxPatLen = 16;

  // Width able to hold 0..pat_len-1 valid-sample counts.
  function automatic int unsigned fill_width(input int unsigned pat_len);
    return (pat_len <= 2) ? 1 : $clog2(pat_len);
  endfunction

  // Width able to hold divider counts 0..div-1.
  function automatic int unsigned div_width(input int unsigned div);
    return (div <= MinDiv) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// Run-control, serial data and match-status signals of the pattern detector.
interface seq_detect_param_if #(
  parameter int unsigned CNT_W = 8
) ();
  logic             en;
  logic             w;
  logic             tick;
  logic             clk_slow;
  logic             out;
  logic             out_held;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output en, w,
    input  tick, clk_slow, out, out_held, match_cnt
  );

  modport slave (
    input  en, w,
    output tick, clk_slow, out, out_held, match_cnt
  );
endinterface

// File: rtl/seq_detect_param_tick_gen.sv
// Divides the system clock into a one-cycle sample strobe plus a visual-only square wave.
module seq_detect_param_tick_gen
  import seq_detect_param_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick,
  output logic clk_slow
);
  localparam int unsigned          CntW   = div_width(DIV);
  localparam logic [CntW-1:0]      CntTop = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick_q, tick_d;
  logic            slow_q, slow_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = tick_q;
    slow_d = slow_q;
    if (en) begin
      cnt_d  = (cnt_q == CntTop) ? '0 : cnt_q + 1'b1;
      tick_d = (cnt_q == CntTop);
      slow_d = slow_q ^ tick_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      slow_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      slow_q <= slow_d;
    end
  end

  // A pending tick is held across an en=0 pause and fires on the first enabled cycle.
  assign tick     = tick_q & en;
  assign clk_slow = slow_q;

endmodule

// File: rtl/seq_detect_param.sv
// Mealy detector for a PAT_LEN-bit serial pattern sampled on divided-rate ticks.
module seq_detect_param
  import seq_detect_param_pkg::*;
#(
  parameter int unsigned        PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b0011,
  parameter int unsigned        DIV     = 4,
  parameter bit                 OVERLAP = 1'b1,
  parameter int unsigned        CNT_W   = 8
) (
  input logic                clk,
  input logic                reset,
  seq_detect_param_if.slave  bus
);
  localparam int unsigned      FillW   = fill_width(PAT_LEN);
  localparam logic [FillW-1:0] FillTop = FillW'(PAT_LEN - 1);

  logic               tick;
  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic [FillW-1:0]   fill_q, fill_d;
  logic               held_q, held_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PAT_LEN-1:0] window;
  logic               match;

  seq_detect_param_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .en       (bus.en),
    .tick     (tick),
    .clk_slow (bus.clk_slow)
  );

  always_comb begin
    window = {hist_q, bus.w};
    match  = tick & (fill_q == FillTop) & (window == PATTERN);
    hist_d = hist_q;
    fill_d = fill_q;
    held_d = held_q;
    cnt_d  = cnt_q;
    if (tick) begin
      hist_d = window[PAT_LEN-2:0];
      if (match && !OVERLAP) begin
        fill_d = '0;
      end else if (fill_q != FillTop) begin
        fill_d = fill_q + 1'b1;
      end
      held_d = match;
      if (match && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
      held_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      held_q <= held_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.tick      = tick;
  assign bus.out       = match;
  assign bus.out_held  = held_q;
  assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench: three detector configurations share one stimulus stream.
module tb_seq_detect_param;
  localparam int NDut   = 3;
  localparam int PatLen = 4;
  localparam int Div    = 4;

  logic clk;
  logic reset;

  seq_detect_param_if #(.CNT_W(8)) if_a ();
  seq_detect_param_if #(.CNT_W(8)) if_b ();
  seq_detect_param_if #(.CNT_W(2)) if_c ();

  seq_detect_param #(
    .PAT_LEN (PatLen), .PATTERN (4'b0011), .DIV (Div), .OVERLAP (1'b1), .CNT_W (8)
  ) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a)
  );

  seq_detect_param #(
    .PAT_LEN (PatLen), .PATTERN (4'b1010), .DIV (Div), .OVERLAP (1'b0), .CNT_W (8)
  ) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b)
  );

  seq_detect_param #(
    .PAT_LEN (PatLen), .PATTERN (4'b1010), .DIV (Div), .OVERLAP (1'b1), .CNT_W (2)
  ) u_dut_c (
    .clk   (clk),
    .reset (reset),
    .bus   (if_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NDut-1:0]      tick;
    logic [NDut-1:0]      slow;
    logic [NDut-1:0]      out;
    logic [NDut-1:0]      held;
    logic [NDut-1:0][7:0] cnt;
  } rec_t;

  rec_t exp_q[$];
  rec_t xr;
  rec_t ar;
  int   total = 0;
  int   bad   = 0;

  // Reference model: pattern value, overlap mode and counter ceiling per detector.
  int pat  [NDut] = '{3, 10, 10};
  bit ov   [NDut] = '{1'b1, 1'b0, 1'b1};
  int cmax [NDut] = '{255, 255, 3};

  int en_edges;          // enabled clock edges since reset
  int hv    [NDut];      // value of the most recent samples
  int nv    [NDut];      // number of samples that count towards a match
  int mcnt  [NDut];
  bit held  [NDut];
  bit slow  [NDut];
  bit m_tick[NDut];
  bit m_hit [NDut];
  int m_win [NDut];

  task automatic model_reset();
    en_edges = 0;
    for (int d = 0; d < NDut; d++) begin
      hv[d] = 0; nv[d] = 0; mcnt[d] = 0; held[d] = 1'b0; slow[d] = 1'b0;
    end
  endtask

  // One clk period: drive inputs, queue the expected outputs, then advance the model.
  task automatic cycle(input bit rst, input bit en_v, input bit w_v);
    rec_t r;
    reset   = rst;
    if_a.en = en_v; if_b.en = en_v; if_c.en = en_v;
    if_a.w  = w_v;  if_b.w  = w_v;  if_c.w  = w_v;
    if (!rst) model_reset();
    for (int d = 0; d < NDut; d++) begin
      m_win[d]  = ((hv[d] * 2) + int'(w_v)) % (1 << PatLen);
      m_tick[d] = rst && en_v && (en_edges > 0) && ((en_edges % Div) == 0);
      m_hit[d]  = m_tick[d] && (nv[d] >= PatLen - 1) && (m_win[d] == pat[d]);
      r.tick[d] = m_tick[d];
      r.out[d]  = m_hit[d];
      r.slow[d] = slow[d];
      r.held[d] = held[d];
      r.cnt[d]  = 8'(mcnt[d]);
    end
    exp_q.push_back(r);
    @(posedge clk);
    if (rst && en_v) begin
      en_edges++;
      for (int d = 0; d < NDut; d++) begin
        if (m_tick[d]) begin
          hv[d]   = m_win[d] % (1 << (PatLen - 1));
          nv[d]   = (m_hit[d] && !ov[d]) ? 0 : ((nv[d] + 1 > PatLen - 1) ? PatLen - 1 : nv[d] + 1);
          held[d] = m_hit[d];
          if (m_hit[d] && mcnt[d] < cmax[d]) mcnt[d]++;
          slow[d] = !slow[d];
        end
      end
    end
    #1;
  endtask

  // Holds w for a whole tick period so the sample lands regardless of phase.
  task automatic sample(input bit b);
    repeat (Div) cycle(1'b1, 1'b1, b);
  endtask

  task automatic do_reset();
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    repeat (Div) cycle(1'b1, 1'b1, 1'b0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      xr = exp_q.pop_front();
      ar.tick = {if_c.tick, if_b.tick, if_a.tick};
      ar.slow = {if_c.clk_slow, if_b.clk_slow, if_a.clk_slow};
      ar.out  = {if_c.out, if_b.out, if_a.out};
      ar.held = {if_c.out_held, if_b.out_held, if_a.out_held};
      ar.cnt[0] = if_a.match_cnt;
      ar.cnt[1] = if_b.match_cnt;
      ar.cnt[2] = 8'(if_c.match_cnt);
      for (int d = 0; d < NDut; d++) begin
        total++;
        if ({ar.tick[d], ar.slow[d], ar.out[d], ar.held[d], ar.cnt[d]} !==
            {xr.tick[d], xr.slow[d], xr.out[d], xr.held[d], xr.cnt[d]}) begin
          bad++;
          $display("FAIL dut%0d t=%0t tick/slow/out/held/cnt got %b %b %b %b %0d want %b %b %b %b %0d",
                   d, $time, ar.tick[d], ar.slow[d], ar.out[d], ar.held[d], ar.cnt[d],
                   xr.tick[d], xr.slow[d], xr.out[d], xr.held[d], xr.cnt[d]);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    if_a.en = 1'b0; if_b.en = 1'b0; if_c.en = 1'b0;
    if_a.w  = 1'b0; if_b.w  = 1'b0; if_c.w  = 1'b0;
    model_reset();
    @(posedge clk); #1;

    // Basic 0011 detection and the 1010 overlap / non-overlap streams.
    do_reset();
    sample(0); sample(0); sample(1); sample(1);
    sample(1); sample(0); sample(1); sample(0); sample(1); sample(0);

    // en pause mid-pattern with w wiggling while frozen.
    do_reset();
    sample(0); sample(0); sample(1);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'($urandom_range(1)));
    sample(1);

    // Reset mid-pattern discards partial history.
    do_reset();
    sample(0); sample(0); sample(1);
    cycle(1'b0, 1'b1, 1'b1);
    repeat (Div) cycle(1'b1, 1'b1, 1'b1);
    sample(1); sample(0); sample(1);

    // Repeated matches drive the narrow counter into saturation.
    do_reset();
    repeat (6) begin sample(0); sample(0); sample(1); sample(1); end
    repeat (8) begin sample(1); sample(0); end

    // Random traffic, including w changes between ticks, en gaps and rare resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(399) != 0), 1'($urandom_range(5) != 0), 1'($urandom_range(1)));
    end

    @(negedge clk); #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain leftover=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
